// File: rtl/xy_fsm_pkg.sv
// rtl/xy_fsm_pkg.sv - shared state and command encodings for the xy_fsm sequencer
package xy_fsm_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;

    localparam logic [1:0] CMD_HOLD = 2'b00;
    localparam logic [1:0] CMD_A    = 2'b10;
    localparam logic [1:0] CMD_B    = 2'b01;
    localparam logic [1:0] CMD_CLR  = 2'b11;

endpackage

// File: rtl/xy_fsm.sv
// rtl/xy_fsm.sv - four-state Moore sequencer stepped by the {x,y} command
module xy_fsm
    import xy_fsm_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic x,
    input  logic y,
    output logic z
);

    state_t     state_q;
    state_t     state_d;
    logic [1:0] cmd;

    assign cmd = {x, y};

    // State register; reset wins over any command on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: hold, clear, or one of the two step commands.
    always_comb begin
        state_d = state_q;
        case (cmd)
            CMD_CLR: begin
                state_d = S0;
            end
            CMD_A: begin
                case (state_q)
                    S0:      state_d = S2;
                    default: state_d = S1;
                endcase
            end
            CMD_B: begin
                case (state_q)
                    S0:      state_d = S1;
                    S3:      state_d = S2;
                    default: state_d = S3;
                endcase
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    // Moore output decoded from the register only, so no input reaches z combinationally.
    assign z = (state_q == S3);

endmodule

// File: tb/tb_xy_fsm.sv
// tb/tb_xy_fsm.sv - directed self-checking bench for xy_fsm
module tb_xy_fsm;

    logic clk;
    logic rst;
    logic x;
    logic y;
    logic z;

    int n_checks;
    int n_errors;

    logic [1:0] exp_tbl [16];

    xy_fsm dut (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .y   (y),
        .z   (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic [1:0] c);
        rst = r;
        {x, y} = c;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string tag, input logic [1:0] s);
        logic [1:0] st;
        st = dut.state_q;
        check({tag, " state"}, st, s);
        check({tag, " z"}, {1'b0, z}, {1'b0, (s == 2'b11)});
    endtask

    task automatic goto_state(input logic [1:0] s);
        step(1'b1, 2'b00);
        case (s)
            2'b01: step(1'b0, 2'b01);
            2'b10: step(1'b0, 2'b10);
            2'b11: begin
                step(1'b0, 2'b01);
                step(1'b0, 2'b01);
            end
            default: ;
        endcase
    endtask

    initial begin
        logic [1:0] walk_cmd [7];
        logic [1:0] walk_st  [7];
        n_checks = 0;
        n_errors = 0;

        exp_tbl[0]  = 2'b00; exp_tbl[1]  = 2'b01; exp_tbl[2]  = 2'b10; exp_tbl[3]  = 2'b00;
        exp_tbl[4]  = 2'b01; exp_tbl[5]  = 2'b11; exp_tbl[6]  = 2'b01; exp_tbl[7]  = 2'b00;
        exp_tbl[8]  = 2'b10; exp_tbl[9]  = 2'b11; exp_tbl[10] = 2'b01; exp_tbl[11] = 2'b00;
        exp_tbl[12] = 2'b11; exp_tbl[13] = 2'b10; exp_tbl[14] = 2'b01; exp_tbl[15] = 2'b00;

        walk_cmd[0] = 2'b10; walk_st[0] = 2'b10;
        walk_cmd[1] = 2'b01; walk_st[1] = 2'b11;
        walk_cmd[2] = 2'b10; walk_st[2] = 2'b01;
        walk_cmd[3] = 2'b01; walk_st[3] = 2'b11;
        walk_cmd[4] = 2'b01; walk_st[4] = 2'b10;
        walk_cmd[5] = 2'b10; walk_st[5] = 2'b01;
        walk_cmd[6] = 2'b10; walk_st[6] = 2'b01;

        rst = 1'b1;
        {x, y} = 2'b10;

        // Reset held for two edges with a step command present.
        step(1'b1, 2'b10);
        expect_state("reset edge1", 2'b00);
        step(1'b1, 2'b10);
        expect_state("reset edge2", 2'b00);

        // Full walk.
        for (int i = 0; i < 7; i++) begin
            step(1'b0, walk_cmd[i]);
            expect_state($sformatf("walk%0d", i), walk_st[i]);
        end

        // Hold in S3 then clear.
        goto_state(2'b11);
        expect_state("reach S3", 2'b11);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'b00);
            expect_state($sformatf("hold S3 %0d", i), 2'b11);
        end
        step(1'b0, 2'b11);
        expect_state("clear from S3", 2'b00);
        goto_state(2'b01);
        step(1'b0, 2'b11);
        expect_state("clear from S1", 2'b00);
        goto_state(2'b10);
        step(1'b0, 2'b11);
        expect_state("clear from S2", 2'b00);

        // Reset mid-operation overrides a step command.
        goto_state(2'b11);
        step(1'b1, 2'b01);
        expect_state("mid reset", 2'b00);
        step(1'b0, 2'b10);
        expect_state("resume", 2'b10);

        // Exhaustive state x command table.
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 4; c++) begin
                goto_state(2'(s));
                step(1'b0, 2'(c));
                expect_state($sformatf("tbl s%0d c%0d", s, c), exp_tbl[s*4 + c]);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
